// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch front end. Owns the PC, drives the i-cache
//             read port and delivers {inst, inst_pc, inst_valid} to decode.
//             A one-entry skid buffer catches a cache response that arrives
//             while decode is holding, and redirects kill in-flight fetches.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    input  logic        icache_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    // IDLE : nothing outstanding, r_pc is the next address to fetch
    // BUSY : live request outstanding for r_pc
    // DRAIN: outstanding request was killed, r_pc holds the redirect target
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;

    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;

    logic        w_resp;
    logic        w_live_resp;
    logic        w_cache_free;
    logic        w_out_load;
    logic        w_accept;
    logic [31:0] w_redirect_addr;
    logic [31:0] w_fetch_addr;

    // Any outstanding request (live or killed) completes on a non-stall cycle
    assign w_resp          = (r_state != ST_IDLE) && !icache_stall;
    // Only a BUSY response not cancelled this very cycle carries real data
    assign w_live_resp     = (r_state == ST_BUSY) && !icache_stall && !redirect_valid;
    assign w_cache_free    = (r_state == ST_IDLE) || w_resp;
    assign w_out_load      = !hold || !r_inst_valid;
    assign w_redirect_addr = redirect_pc & 32'hFFFF_FFFC;

    // Sequential fetch only advances past r_pc once its live response is back
    assign w_fetch_addr = redirect_valid ? w_redirect_addr :
                          (r_state == ST_BUSY && w_resp) ? (r_pc + 32'd4) : r_pc;

    // A held, full output means any new response would have nowhere to go
    // (the skid may be occupied), so only a redirect may issue past a hold.
    assign icache_re   = reset_n && w_cache_free &&
                         (redirect_valid || !(hold && r_inst_valid));
    assign icache_addr = w_fetch_addr;
    assign w_accept    = icache_re && !icache_stall;

    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

    // Next-state and next-PC selection for the request FSM
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_cache_free) begin
            w_pc_nxt    = w_fetch_addr;
            w_state_nxt = w_accept ? ST_BUSY : ST_IDLE;
        end else if (redirect_valid) begin
            w_pc_nxt    = w_redirect_addr;
            w_state_nxt = ST_DRAIN;
        end
    end

    // FSM state and PC register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Output register and skid buffer: redirect kills, then load, then park
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inst       <= NOP_INST;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= 32'd0;
            r_skid_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_inst       <= r_skid_inst;
                r_inst_pc    <= r_skid_pc;
                r_inst_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_live_resp) begin
                r_inst       <= icache_dout;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
            end else begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
        end else if (w_live_resp) begin
            r_skid_inst  <= icache_dout;
            r_skid_pc    <= r_pc;
            r_skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A behavioural i-cache and
//             an instruction-stream model (expected next PC delivered, next
//             request address) judge directed scenarios and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_2000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        icache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Cache model: at most one pending request, possibly stale after reset
    bit          pend      = 1'b0;
    bit          pend_live = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    // Stream model
    bit          armed       = 1'b0;
    logic [31:0] exp_pc      = C_RESET_PC;
    logic [31:0] exp_req     = C_RESET_PC;
    bit          after_kill  = 1'b0;
    bit          after_reset = 1'b0;
    bit          held        = 1'b0;
    int          idle_cycles = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .icache_stall   (icache_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (hold),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive inputs (just after a falling edge), let them settle, run the
    // per-cycle model checks. Caller may add directed checks afterwards.
    task automatic begin_cycle(input logic rn, input logic st, input logic hd,
                               input logic rv, input logic [31:0] rp);
        reset_n        = rn;
        icache_stall   = st;
        hold           = hd;
        redirect_valid = rv;
        redirect_pc    = rp;
        icache_dout    = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        if (armed) begin
            if (!reset_n) begin
                chk("re_in_reset", 32'(icache_re), 32'd0);
            end else begin
                if (pend && pend_live && icache_stall)
                    chk("re_while_outstanding", 32'(icache_re), 32'd0);
                if (icache_re)
                    chk("req_addr", icache_addr,
                        redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : exp_req);
            end
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_data", inst, mem_word(exp_pc));
            end else begin
                chk("inst_nop", inst, C_NOP);
            end
            if (after_kill)  chk("valid_after_kill", 32'(inst_valid), 32'd0);
            if (after_reset) chk("pc_after_reset", inst_pc, 32'd0);
            if (held)        chk("valid_while_held", 32'(inst_valid), 32'd1);
            if (idle_cycles > 40) begin
                chk("progress_timeout", 32'(idle_cycles), 32'd0);
                idle_cycles = 0;
            end
        end
    endtask

    // Capture the cycle, take the rising edge, advance the models
    task automatic end_cycle();
        logic        s_re    = icache_re;
        logic [31:0] s_addr  = icache_addr;
        logic        s_valid = inst_valid;
        logic        s_st    = icache_stall;
        logic        s_hd    = hold;
        logic        s_rv    = redirect_valid;
        logic [31:0] s_tgt   = redirect_pc & 32'hFFFF_FFFC;
        logic        s_rn    = reset_n;
        bit          resp;
        bit          acc;
        @(posedge clk);
        resp = pend && !s_st;
        acc  = s_re && !s_st;
        if (resp) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
        end
        if (!s_rn) begin
            armed       = 1'b1;
            exp_pc      = C_RESET_PC;
            exp_req     = C_RESET_PC;
            pend_live   = 1'b0;
            after_kill  = 1'b1;
            after_reset = 1'b1;
            held        = 1'b0;
            idle_cycles = 0;
        end else begin
            after_reset = 1'b0;
            if (acc) begin
                pend_live = 1'b1;
                exp_req   = s_addr + 32'd4;
            end
            if (s_rv) begin
                exp_pc      = s_tgt;
                if (!acc) exp_req = s_tgt;
                after_kill  = 1'b1;
                held        = 1'b0;
                idle_cycles = 0;
            end else begin
                after_kill = 1'b0;
                held       = s_valid && s_hd;
                if (s_valid && !s_hd) begin
                    exp_pc      = exp_pc + 32'd4;
                    idle_cycles = 0;
                end else if (!s_hd) begin
                    idle_cycles++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic rn, input logic st, input logic hd,
                       input logic rv, input logic [31:0] rp);
        begin_cycle(rn, st, hd, rv, rp);
        end_cycle();
    endtask

    // Directed scenarios followed by random traffic
    initial begin
        reset_n = 1'b0; icache_stall = 1'b0; hold = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; icache_dout = 32'd0;
        @(negedge clk);

        // Reset, then an always-hit stream
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, C_NOP);
        chk("rst_pc", inst_pc, 32'd0);
        begin_cycle(1, 0, 0, 0, 0);
        chk("first_re", 32'(icache_re), 32'd1);
        chk("first_addr", icache_addr, 32'h2000);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("resp_cycle_valid", 32'(inst_valid), 32'd0); end_cycle();
        for (int k = 0; k < 3; k++) begin
            begin_cycle(1, 0, 0, 0, 0);
            chk("hit_valid", 32'(inst_valid), 32'd1);
            chk("hit_pc", inst_pc, 32'h2000 + 32'(k * 4));
            end_cycle();
        end

        // Miss on 0x2004
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);                                  // req 0x2000
        cyc(1, 0, 0, 0, 0);                                  // resp 0x2000, req 0x2004
        begin_cycle(1, 1, 0, 0, 0); chk("miss_c2_pc", inst_pc, 32'h2000); end_cycle();
        begin_cycle(1, 1, 0, 0, 0); chk("miss_valid", 32'(inst_valid), 32'd0); end_cycle();
        begin_cycle(1, 1, 0, 0, 0); chk("miss_valid2", 32'(inst_valid), 32'd0); end_cycle();
        begin_cycle(1, 0, 0, 0, 0);
        chk("resume_re", 32'(icache_re), 32'd1);
        chk("resume_addr", icache_addr, 32'h2008);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("miss_deliver", inst_pc, 32'h2004); end_cycle();

        // Hold while 0x2008 is at the output and 0x200C responds
        begin_cycle(1, 0, 1, 0, 0);
        chk("hold_pc", inst_pc, 32'h2008);
        chk("hold_re", 32'(icache_re), 32'd0);
        end_cycle();
        begin_cycle(1, 0, 1, 0, 0);
        chk("hold2_pc", inst_pc, 32'h2008);
        chk("hold2_re", 32'(icache_re), 32'd0);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0);
        chk("unhold_re", 32'(icache_re), 32'd1);
        chk("unhold_addr", icache_addr, 32'h2010);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("skid_pc", inst_pc, 32'h200C); end_cycle();

        // Redirect to 0x3003 during a 2-cycle miss
        begin_cycle(1, 1, 0, 1, 32'h3003); chk("pre_redir_pc", inst_pc, 32'h2010); end_cycle();
        begin_cycle(1, 1, 0, 0, 0); chk("drain_valid", 32'(inst_valid), 32'd0); end_cycle();
        begin_cycle(1, 0, 0, 0, 0);
        chk("drain_re", 32'(icache_re), 32'd1);
        chk("drain_addr", icache_addr, 32'h3000);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("killed_hidden", 32'(inst_valid), 32'd0); end_cycle();

        // Redirect with a same-cycle response and hold
        begin_cycle(1, 0, 1, 1, 32'h4000);
        chk("redir_target_pc", inst_pc, 32'h3000);
        chk("redir_re", 32'(icache_re), 32'd1);
        chk("redir_addr", icache_addr, 32'h4000);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("redir_valid", 32'(inst_valid), 32'd0); end_cycle();
        begin_cycle(1, 1, 0, 0, 0); chk("redir_deliver", inst_pc, 32'h4000); end_cycle();

        // Reset with 0x4004 outstanding, stale response after release
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst", inst, C_NOP);
        begin_cycle(1, 0, 0, 0, 0);
        chk("post_rst_re", 32'(icache_re), 32'd1);
        chk("post_rst_addr", icache_addr, 32'h2000);
        end_cycle();
        begin_cycle(1, 0, 0, 0, 0); chk("stale_ignored", 32'(inst_valid), 32'd0); end_cycle();
        begin_cycle(1, 0, 0, 0, 0);
        chk("post_rst_pc", inst_pc, 32'h2000);
        chk("post_rst_inst", inst, mem_word(32'h2000));
        end_cycle();

        // Random traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 4),
                32'($urandom_range(32'h1000, 32'h8000)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence itself never completes
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
